// File: rtl/tone_player_pkg.sv
// Shared constants and types for the multi-channel tone sequencer.
package tone_player_pkg;

  localparam logic [31:0] HW_VER = 32'h0000_0001;

  localparam int unsigned ADDR_VER      = 'h00;
  localparam int unsigned ADDR_CTRL     = 'h04;
  localparam int unsigned ADDR_CH_SEL   = 'h08;
  localparam int unsigned ADDR_NOTE_DIV = 'h0C;
  localparam int unsigned ADDR_NOTE_LEN = 'h10;
  localparam int unsigned ADDR_STATUS   = 'h14;
  localparam int unsigned ADDR_LEVEL    = 'h18;
  localparam int unsigned ADDR_TICK     = 'h1C;
  localparam int unsigned ADDR_GAP      = 'h20;

  typedef logic [1:0] state_t;
  localparam state_t IDLE = 2'd0;
  localparam state_t PLAY = 2'd1;
  localparam state_t GAP  = 2'd2;

  typedef struct packed {
    logic [15:0] div;
    logic [15:0] len;
  } note_t;

endpackage

// File: rtl/tone_channel.sv
// One sequencer channel: note FIFO, play/gap FSM, tick prescaler, half-period divider and pin flop.
module tone_channel
  import tone_player_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned LW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic [31:0]   tick,
  input  logic [15:0]   gap,
  input  logic          push,
  input  note_t         push_note,
  input  logic          flush,
  output logic          busy,
  output logic          full,
  output logic          overflow,
  output logic [LW-1:0] level,
  output logic          pin
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] PtrInc = 1;

  note_t       mem [DEPTH];
  logic [AW:0] wr_ptr_q, rd_ptr_q;
  state_t      state_q, state_d;
  logic [15:0] div_q, div_d, len_q, len_d;
  logic [15:0] divcnt_q, divcnt_d, lencnt_q, lencnt_d;
  logic [31:0] presc_q, presc_d;
  logic        pin_q, pin_d, ovf_q;
  logic        empty, pop, push_ok, next_note;
  logic        presc_tick, note_end, gap_end;
  note_t       head;

  assign level    = wr_ptr_q - rd_ptr_q;
  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (level == LW'(DEPTH));
  assign head     = mem[rd_ptr_q[AW-1:0]];
  // A pop in the same cycle frees the slot, so a push at full is still accepted.
  assign push_ok  = push && !flush && (!full || pop);
  assign busy     = (state_q != IDLE);
  assign overflow = ovf_q;
  assign pin      = pin_q;

  assign presc_tick = (presc_q >= tick);
  assign note_end   = (len_q == 16'd0) || (presc_tick && (lencnt_q >= len_q - 16'd1));
  assign gap_end    = (gap == 16'd0) || (presc_tick && (lencnt_q >= gap - 16'd1));

  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    len_d     = len_q;
    divcnt_d  = divcnt_q;
    lencnt_d  = lencnt_q;
    presc_d   = presc_tick ? 32'd0 : presc_q + 32'd1;
    pin_d     = pin_q;
    pop       = 1'b0;
    next_note = 1'b0;
    if (flush || !en) begin
      state_d = IDLE;
      pin_d   = 1'b0;
    end else begin
      unique case (state_q)
        PLAY: begin
          if (div_q == 16'd0) begin
            pin_d = 1'b0;
          end else if (divcnt_q >= div_q - 16'd1) begin
            pin_d    = !pin_q;
            divcnt_d = 16'd0;
          end else begin
            divcnt_d = divcnt_q + 16'd1;
          end
          if (presc_tick) lencnt_d = lencnt_q + 16'd1;
          if (note_end) begin
            pin_d = 1'b0;
            if (gap != 16'd0) begin
              state_d  = GAP;
              presc_d  = 32'd0;
              lencnt_d = 16'd0;
            end else begin
              next_note = 1'b1;
            end
          end
        end
        GAP: begin
          if (gap_end) next_note = 1'b1;
          else if (presc_tick) lencnt_d = lencnt_q + 16'd1;
        end
        default: next_note = 1'b1;
      endcase
      if (next_note) begin
        if (!empty) begin
          pop      = 1'b1;
          state_d  = PLAY;
          div_d    = head.div;
          len_d    = head.len;
          divcnt_d = 16'd0;
          lencnt_d = 16'd0;
          presc_d  = 32'd0;
          pin_d    = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q[AW-1:0]] <= push_note;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
      state_q  <= IDLE;
      div_q    <= '0;
      len_q    <= '0;
      divcnt_q <= '0;
      lencnt_q <= '0;
      presc_q  <= '0;
      pin_q    <= 1'b0;
    end else begin
      if (flush) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        ovf_q    <= 1'b0;
      end else begin
        if (push_ok) wr_ptr_q <= wr_ptr_q + PtrInc;
        if (pop) rd_ptr_q <= rd_ptr_q + PtrInc;
        if (push && !push_ok) ovf_q <= 1'b1;
      end
      state_q  <= state_d;
      div_q    <= div_d;
      len_q    <= len_d;
      divcnt_q <= divcnt_d;
      lencnt_q <= lencnt_d;
      presc_q  <= presc_d;
      pin_q    <= pin_d;
    end
  end

endmodule

// File: rtl/tone_player.sv
// Register file and read mux for the FIFO-fed tone sequencer; one tone_channel per pin.
// Optional inter-note silence is enabled with the TONE_PLAYER_GAP_EN macro.
module tone_player
  import tone_player_pkg::*;
#(
  parameter int unsigned ADDRWIDTH = 6,
  parameter int unsigned NCH       = 2,
  parameter int unsigned DEPTH     = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rd,
  input  logic [ADDRWIDTH-1:0] raddr,
  output logic [31:0]          rdata,
  input  logic                 wr,
  input  logic [ADDRWIDTH-1:0] waddr,
  input  logic [31:0]          wdata,
  output logic [NCH-1:0]       tone_pin
);

  localparam int unsigned CHW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int unsigned LW  = $clog2(DEPTH) + 1;

  logic           en_q;
  logic [CHW-1:0] ch_sel_q;
  logic [15:0]    note_div_q, note_len_q;
  logic [31:0]    tick_q, rdata_q, rdata_d;
  logic [15:0]    gap_val;
  logic           wr_ctrl, push_any, flush_any;
  note_t          new_note;
  logic [NCH-1:0] busy, full, ovf;
  logic [LW-1:0]  level [NCH];
  logic [LW-1:0]  sel_level;

  assign wr_ctrl   = wr && (waddr == ADDRWIDTH'(ADDR_CTRL));
  assign flush_any = wr_ctrl && wdata[1];
  assign push_any  = wr && (waddr == ADDRWIDTH'(ADDR_NOTE_LEN));
  assign new_note  = {note_div_q, wdata[15:0]};

`ifdef TONE_PLAYER_GAP_EN
  logic [15:0] gap_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) gap_q <= '0;
    else if (wr && (waddr == ADDRWIDTH'(ADDR_GAP))) gap_q <= wdata[15:0];
  end
  assign gap_val = gap_q;
`else
  assign gap_val = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q       <= 1'b0;
      ch_sel_q   <= '0;
      note_div_q <= '0;
      note_len_q <= '0;
      tick_q     <= '0;
    end else if (wr) begin
      if (wr_ctrl) en_q <= wdata[0];
      if (waddr == ADDRWIDTH'(ADDR_CH_SEL)) ch_sel_q <= (NCH > 1) ? wdata[CHW-1:0] : '0;
      if (waddr == ADDRWIDTH'(ADDR_NOTE_DIV)) note_div_q <= wdata[15:0];
      if (push_any) note_len_q <= wdata[15:0];
      if (waddr == ADDRWIDTH'(ADDR_TICK)) tick_q <= wdata;
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    tone_channel #(
      .DEPTH (DEPTH)
    ) u_ch (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (en_q),
      .tick      (tick_q),
      .gap       (gap_val),
      .push      (push_any && (ch_sel_q == CHW'(i))),
      .push_note (new_note),
      .flush     (flush_any && (ch_sel_q == CHW'(i))),
      .busy      (busy[i]),
      .full      (full[i]),
      .overflow  (ovf[i]),
      .level     (level[i]),
      .pin       (tone_pin[i])
    );
  end

  always_comb begin
    sel_level = '0;
    for (int i = 0; i < NCH; i++) begin
      if (ch_sel_q == CHW'(i)) sel_level = level[i];
    end
  end

  always_comb begin
    rdata_d = 32'd0;
    case (raddr)
      ADDRWIDTH'(ADDR_VER):      rdata_d = HW_VER;
      ADDRWIDTH'(ADDR_CTRL):     rdata_d = {31'd0, en_q};
      ADDRWIDTH'(ADDR_CH_SEL):   rdata_d = 32'(ch_sel_q);
      ADDRWIDTH'(ADDR_NOTE_DIV): rdata_d = {16'd0, note_div_q};
      ADDRWIDTH'(ADDR_NOTE_LEN): rdata_d = {16'd0, note_len_q};
      ADDRWIDTH'(ADDR_STATUS):   rdata_d = {8'd0, 8'(ovf), 8'(full), 8'(busy)};
      ADDRWIDTH'(ADDR_LEVEL):    rdata_d = 32'(sel_level);
      ADDRWIDTH'(ADDR_TICK):     rdata_d = tick_q;
`ifdef TONE_PLAYER_GAP_EN
      ADDRWIDTH'(ADDR_GAP):      rdata_d = {16'd0, gap_val};
`endif
      default:                   rdata_d = 32'd0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdata_q <= '0;
    else if (rd) rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: tb/tb_tone_player.sv
// Bench for tone_player: directed scenarios plus random traffic against a note-level reference model.
module tb_tone_player;

  localparam int NCH   = 2;
  localparam int DEPTH = 8;

  localparam logic [5:0] A_VER  = 6'h00;
  localparam logic [5:0] A_CTRL = 6'h04;
  localparam logic [5:0] A_SEL  = 6'h08;
  localparam logic [5:0] A_DIV  = 6'h0C;
  localparam logic [5:0] A_LEN  = 6'h10;
  localparam logic [5:0] A_STAT = 6'h14;
  localparam logic [5:0] A_LVL  = 6'h18;
  localparam logic [5:0] A_TICK = 6'h1C;
  localparam logic [5:0] A_GAP  = 6'h20;

  logic           clk, rst_n, rd, wr;
  logic [5:0]     raddr, waddr;
  logic [31:0]    rdata, wdata;
  logic [NCH-1:0] tone_pin;

  tone_player #(
    .ADDRWIDTH (6),
    .NCH       (NCH),
    .DEPTH     (DEPTH)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd       (rd),
    .raddr    (raddr),
    .rdata    (rdata),
    .wr       (wr),
    .waddr    (waddr),
    .wdata    (wdata),
    .tone_pin (tone_pin)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: per channel a queue of notes, a phase (0 idle, 1 play, 2 gap) and the
  // number of clocks spent in the current phase; the pin is derived from elapsed time.
  typedef struct {
    int div;
    int len;
  } mnote_t;

  mnote_t      mq [NCH][$];
  mnote_t      cur [NCH];
  int          ph [NCH];
  int          k [NCH];
  bit          movf [NCH];
  bit          en_m;
  int          sel_m, div_m, len_m, tick_m, gap_m;
  logic [31:0] exp_rdata;
  int          n_assert, n_fail;

  task automatic m_reset();
    for (int c = 0; c < NCH; c++) begin
      mq[c].delete();
      ph[c] = 0;
      k[c] = 0;
      movf[c] = 0;
    end
    en_m = 0; sel_m = 0; div_m = 0; len_m = 0; tick_m = 0; gap_m = 0;
    exp_rdata = 32'd0;
  endtask

  function automatic logic [31:0] m_read(input logic [5:0] a);
    logic [31:0] r;
    r = 32'd0;
    case (a)
      A_VER:  r = 32'h1;
      A_CTRL: r = {31'd0, en_m};
      A_SEL:  r = 32'(sel_m);
      A_DIV:  r = 32'(div_m);
      A_LEN:  r = 32'(len_m);
      A_STAT: begin
        for (int c = 0; c < NCH; c++) begin
          r[c]      = (ph[c] != 0);
          r[8 + c]  = (mq[c].size() == DEPTH);
          r[16 + c] = movf[c];
        end
      end
      A_LVL:  r = 32'(mq[sel_m].size());
      A_TICK: r = 32'(tick_m);
      A_GAP:  r = 32'(gap_m);
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  function automatic logic exp_pin(input int c);
    if (ph[c] == 1 && cur[c].div != 0) return ((k[c] / cur[c].div) % 2) == 1;
    return 1'b0;
  endfunction

  task automatic m_step(input bit do_push, input mnote_t pn, input bit do_flush);
    for (int c = 0; c < NCH; c++) begin
      bit nxt;
      nxt = 0;
      if (do_flush && sel_m == c) begin
        mq[c].delete();
        ph[c] = 0;
        movf[c] = 0;
      end else begin
        if (!en_m) ph[c] = 0;
        else if (ph[c] == 0) nxt = 1;
        else if (ph[c] == 1) begin
          if (cur[c].len == 0 || k[c] + 1 >= cur[c].len * (tick_m + 1)) begin
            if (gap_m != 0) begin
              ph[c] = 2;
              k[c] = 0;
            end else nxt = 1;
          end else k[c]++;
        end else begin
          if (k[c] + 1 >= gap_m * (tick_m + 1)) nxt = 1;
          else k[c]++;
        end
        if (nxt) begin
          if (mq[c].size() > 0) begin
            cur[c] = mq[c].pop_front();
            ph[c] = 1;
            k[c] = 0;
          end else ph[c] = 0;
        end
        if (do_push && sel_m == c) begin
          if (mq[c].size() < DEPTH) mq[c].push_back(pn);
          else movf[c] = 1;
        end
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic check_outputs();
    for (int c = 0; c < NCH; c++) chk($sformatf("pin%0d", c), 32'(tone_pin[c]), 32'(exp_pin(c)));
    chk("rdata", rdata, exp_rdata);
  endtask

  task automatic cyc(input bit w, input logic [5:0] wa, input logic [31:0] wd,
                     input bit r, input logic [5:0] ra);
    logic [31:0] rexp;
    mnote_t      pn;
    bit          do_push, do_flush;
    wr = w; waddr = wa; wdata = wd; rd = r; raddr = ra;
    rexp     = m_read(ra);
    do_push  = w && (wa == A_LEN);
    do_flush = w && (wa == A_CTRL) && wd[1];
    pn.div   = div_m;
    pn.len   = int'(wd[15:0]);
    @(posedge clk);
    m_step(do_push, pn, do_flush);
    if (w) begin
      case (wa)
        A_CTRL: en_m = wd[0];
        A_SEL:  sel_m = int'(wd) & (NCH - 1);
        A_DIV:  div_m = int'(wd[15:0]);
        A_LEN:  len_m = int'(wd[15:0]);
        A_TICK: tick_m = int'(wd);
`ifdef TONE_PLAYER_GAP_EN
        A_GAP:  gap_m = int'(wd[15:0]);
`endif
        default: ;
      endcase
    end
    if (r) exp_rdata = rexp;
    #1;
    wr = 1'b0; rd = 1'b0;
    check_outputs();
  endtask

  task automatic wreg(input logic [5:0] a, input logic [31:0] d);
    cyc(1'b1, a, d, 1'b0, 6'h00);
  endtask

  task automatic rreg(input logic [5:0] a);
    cyc(1'b0, 6'h00, 32'd0, 1'b1, a);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 6'h00, 32'd0, 1'b0, 6'h00);
  endtask

  task automatic push_note(input int d, input int l);
    wreg(A_DIV, 32'(d));
    wreg(A_LEN, 32'(l));
  endtask

  initial begin
    int r;
    n_assert = 0; n_fail = 0;
    rst_n = 1'b0; rd = 1'b0; wr = 1'b0; raddr = '0; waddr = '0; wdata = '0;
    m_reset();
    #1;
    chk("reset_pin", 32'(tone_pin), 32'd0);
    chk("reset_rdata", rdata, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    rreg(A_VER);
    chk("ver", rdata, 32'h1);
    rreg(6'h24);
    rreg(A_STAT);

    // Single note on channel 0: div 4, len 3, TICK 9.
    wreg(A_TICK, 32'd9);
    wreg(A_SEL, 32'd0);
    push_note(4, 3);
    wreg(A_CTRL, 32'd1);
    idle(3);
    rreg(A_STAT);
    chk("busy0", rdata & 32'h1, 32'h1);
    idle(30);
    rreg(A_STAT);

    // Channel 1: tone then rest, back to back.
    wreg(A_SEL, 32'd1);
    push_note(3, 2);
    push_note(0, 2);
    idle(45);
    rreg(A_STAT);
    chk("idle_after_rest", rdata, 32'd0);

    // Overflow then flush on channel 0.
    wreg(A_CTRL, 32'd0);
    wreg(A_SEL, 32'd0);
    for (int i = 0; i < DEPTH + 1; i++) push_note(i + 1, 2);
    rreg(A_LVL);
    chk("level_full", rdata, 32'(DEPTH));
    rreg(A_STAT);
    chk("full_ovf", rdata & 32'h0001_0100, 32'h0001_0100);
    wreg(A_CTRL, 32'd2);
    rreg(A_LVL);
    chk("level_flushed", rdata, 32'd0);
    rreg(A_STAT);

    // EN dropped mid-note, then resumed.
    wreg(A_TICK, 32'd1);
    push_note(2, 5);
    push_note(1, 3);
    push_note(3, 2);
    wreg(A_CTRL, 32'd1);
    idle(4);
    wreg(A_CTRL, 32'd0);
    idle(1);
    rreg(A_STAT);
    rreg(A_LVL);
    chk("level_kept", rdata, 32'd2);
    wreg(A_CTRL, 32'd1);
    idle(16);

    // Push coinciding with the first pop from a full FIFO.
    wreg(A_CTRL, 32'd2);
    wreg(A_TICK, 32'd0);
    for (int i = 0; i < DEPTH; i++) push_note(1, 2);
    wreg(A_CTRL, 32'd1);
    wreg(A_LEN, 32'd2);
    rreg(A_LVL);
    chk("level_pushpop", rdata, 32'(DEPTH));
    rreg(A_STAT);
    chk("no_ovf", rdata & 32'h0001_0000, 32'd0);
    idle(2 * DEPTH + 6);

    // Random traffic on both channels with a fixed tick.
    wreg(A_CTRL, 32'd0);
    wreg(A_CTRL, 32'd2);
    wreg(A_SEL, 32'd1);
    wreg(A_CTRL, 32'd2);
    wreg(A_TICK, 32'd1);
    wreg(A_CTRL, 32'd1);
    for (int i = 0; i < 500; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 25) wreg(A_DIV, $urandom_range(0, 4));
      else if (r < 50) wreg(A_LEN, $urandom_range(0, 3));
      else if (r < 58) wreg(A_SEL, $urandom_range(0, NCH - 1));
      else if (r < 60) wreg(A_CTRL, 32'd3);
      else if (r < 62) wreg(A_CTRL, 32'd0);
      else if (r < 67) wreg(A_CTRL, 32'd1);
      else if (r < 80) rreg(A_STAT);
      else if (r < 90) rreg(A_LVL);
      else idle(1);
    end

    // Gap register and inter-note silence (GAP stays 0 when the feature is absent).
    wreg(A_CTRL, 32'd0);
    wreg(A_SEL, 32'd1);
    wreg(A_CTRL, 32'd2);
    wreg(A_SEL, 32'd0);
    wreg(A_CTRL, 32'd2);
    wreg(A_TICK, 32'd0);
    wreg(A_GAP, 32'd2);
    rreg(A_GAP);
    push_note(1, 4);
    push_note(1, 4);
    wreg(A_CTRL, 32'd1);
    idle(16);
    rreg(A_STAT);
    wreg(A_GAP, 32'd0);

    // Asynchronous reset in the middle of a note.
    wreg(A_TICK, 32'd3);
    push_note(2, 6);
    idle(6);
    rreg(A_VER);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_pin", 32'(tone_pin), 32'd0);
    chk("async_rdata", rdata, 32'd0);
    m_reset();
    @(negedge clk);
    rst_n = 1'b1;
    rreg(A_LVL);
    rreg(A_STAT);
    rreg(A_TICK);
    idle(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/tone_player.md
# tone_player

Multi-channel, FIFO-fed tone sequencer on the CPU register bus: the successor to the single-tone buzzer. Software queues notes per channel, each a {half-period, duration} pair. Every channel plays its queue back-to-back with no CPU involvement and drives one square-wave pin. It sits beside the other bus peripherals and uses the same rd/raddr/rdata and wr/waddr/wdata interface.

## Interface
- `ADDRWIDTH`, 6: byte address width of the register window.
- `NCH`, 2: number of channels and output pins (1..8).
- `DEPTH`, 8: note FIFO entries per channel (power of two, ≥2).
- `clk` in 1: single system clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `rd` in 1: read strobe.
- `raddr` in ADDRWIDTH: read address.
- `rdata` out 32: registered read data; resets to 0.
- `wr` in 1: write strobe.
- `waddr` in ADDRWIDTH: write address.
- `wdata` in 32: write data.
- `tone_pin` out NCH: per-channel square wave; resets to 0.

## Operation
- Register map:
  - 0x00 VER (RO) = 0x01.
  - 0x04 CTRL: bit0 EN. Bit1 FLUSH is self-clearing and acts on the selected channel.
  - 0x08 CH_SEL: bits log2(NCH)-1:0.
  - 0x0C NOTE_DIV: bits 15:0, staging register only.
  - 0x10 NOTE_LEN: bits 15:0. A write pushes {NOTE_DIV, NOTE_LEN} into the FIFO of CH_SEL.
  - 0x14 STATUS (RO): [7:0] busy, [15:8] full, [23:16] overflow (sticky).
  - 0x18 LEVEL (RO): occupancy of CH_SEL.
  - 0x1C TICK: 32 bits. One duration tick = TICK+1 clocks.
  - 0x20 GAP: see Configuration.
- Unmapped reads return 0. Writes to RO addresses are ignored.
- Per-channel FSM:
  - IDLE → PLAY when EN=1 and FIFO is not empty. This pops the head and loads div and len.
  - PLAY: the tone half-period is div clocks. div=0 is a rest, with the pin held low.
  - When len ticks have elapsed, the channel pops the next entry if one is present and stays in PLAY. Otherwise it goes to IDLE.
  - With gap enabled, PLAY goes to GAP before the next note.
- busy=1 in every state except IDLE.
- Each channel has its own tick prescaler, reset at every note start. Note duration is therefore exactly len·(TICK+1) clocks.
- len=0: the entry is popped and discarded. The next entry is popped on the following cycle.
- The pin starts low at each note start. It is low in IDLE, GAP and rests.
- EN 1→0: all channels drop to IDLE on the next clock and pins go low. FIFO contents are retained.
- Push when full: the entry is dropped and the overflow bit is set.
- FLUSH: empties the selected FIFO, aborts its current note (→IDLE), and clears its overflow bit.
- Same-cycle push and pop on one FIFO: both take effect, and the level is unchanged.
- FLUSH and push in the same cycle: FLUSH wins and the pushed entry is lost.
- Arithmetic: divcnt and lencnt are 16-bit, and the prescaler is 32-bit. All compares are ≥ so that changing TICK mid-note cannot overrun.

## Timing
- Read latency is 1 clock: `rdata` is updated on the edge after `rd`. `rdata` holds its value when rd=0.
- Write takes effect on the edge where wr=1. A NOTE_LEN push is visible in LEVEL from the next cycle.
- Pop in IDLE at edge N puts the channel in PLAY at N+1. The first pin rise is at edge N+1+div.
- Note-to-note switch (no gap) has zero dead cycles: the next note starts on the edge after the last tick of the previous note.
- Reset mid-operation clears FIFOs, all registers, the FSMs to IDLE, `rdata`, and the pins to 0 asynchronously.

## Configuration
- `TONE_PLAYER_GAP_EN` defined:
  - GAP register (0x20, 16 bits, reset 0) is present.
  - A nonzero GAP inserts GAP ticks of silence (GAP state) after every note, including the last one.
  - GAP=0 behaves as if the feature were absent.
- `TONE_PLAYER_GAP_EN` undefined:
  - There is no GAP state.
  - 0x20 reads 0 and writes to it are ignored.

## Structure
- Package `tone_player_pkg`: register address constants, HW_VER, the state enum {IDLE, PLAY, GAP}, and the note entry layout (div[15:0], len[15:0]).
- Sub-module `tone_channel` (instantiated NCH times) holds the FIFO, FSM, prescaler, divider and pin flop. The top level keeps the register file and read mux.

## Test plan
- NCH=2 setup: TICK=9, channel 0, push {div=4,len=3}, EN=1.
  - Required: busy0=1, pin toggles every 4 clocks for 30 clocks, then busy0=0 and pin=0.
- Push two notes {3,2} and {0,2} on channel 1.
  - Required: 20 clocks of a 6-clock-period square wave, then 20 clocks low.
  - Required: no dead cycle between the notes.
- Push DEPTH+1 entries with EN=0.
  - Required: LEVEL=DEPTH, full bit set, overflow bit set.
  - Then FLUSH: LEVEL=0 and overflow cleared.
- EN cleared mid-note.
  - Required: pin=0 and busy=0 on the next clock, LEVEL unchanged.
  - Setting EN again resumes with the next queued entry.
- Simultaneous push and pop at LEVEL=DEPTH: no overflow, LEVEL stays DEPTH.
- With `TONE_PLAYER_GAP_EN`, GAP=2, TICK=0, two notes {1,4}.
  - Required: 4 toggling clocks, 2 low clocks, 4 toggling clocks, 2 low clocks.
  - Also: rst_n asserted mid-note drives the pins and `rdata` to 0 immediately.
